window_3x3_gen: RTL and testbench

Streaming 3x3 sliding-window generator that sits directly upstream of the convolution datapath in the image pipeline. Accepts one raster-order pixel per valid cycle for an IMG_W x IMG_H frame. Keeps two line buffers plus a 3x3 register window, tracking column and row internally with wrapping counters. Emits a full 3x3 neighbourhood with its centre coordinates and pulses frame_done on the last pixel of each frame.

---
 rtl/window_3x3_gen.sv | 108 ++++++++++
 tb/tb_window_3x3_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers feed the right-hand
// column of a 3x3 register window; outputs are registered and gated on position.
module window_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 640,
  parameter int DW    = 8,
  parameter int CW    = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_pixel,
  output logic            win_valid,
  output logic [9*DW-1:0] win_data,
  output logic [CW-1:0]   win_row,
  output logic [CW-1:0]   win_col,
  output logic            frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [DW-1:0] lb_top [0:IMG_W-1];
  logic [DW-1:0] lb_mid [0:IMG_W-1];

  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   row_q, row_d;
  logic [9*DW-1:0] win_q, win_d, win_shift;
  logic [DW-1:0]   new_col [3];
  logic [AW-1:0]   col_idx;

  logic            win_valid_q, frame_done_q;
  logic [9*DW-1:0] win_data_q;
  logic [CW-1:0]   win_row_q, win_col_q;
  logic            win_gate, last_pix;

  assign col_idx    = col_q[AW-1:0];
  assign new_col[0] = lb_top[col_idx];
  assign new_col[1] = lb_mid[col_idx];
  assign new_col[2] = in_pixel;

  // Each window row shifts left by one element and takes its line's new pixel on the right.
  for (genvar gi = 0; gi < 3; gi++) begin : g_shift
    assign win_shift[DW*(3*gi+0) +: DW] = win_q[DW*(3*gi+1) +: DW];
    assign win_shift[DW*(3*gi+1) +: DW] = win_q[DW*(3*gi+2) +: DW];
    assign win_shift[DW*(3*gi+2) +: DW] = new_col[gi];
  end

  assign win_gate = in_valid && (row_q >= TWO) && (col_q >= TWO);
  assign last_pix = in_valid && (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (in_valid) begin
      win_d = win_shift;
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // Line buffers carry no reset so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top[col_idx] <= lb_mid[col_idx];
      lb_mid[col_idx] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_gate;
      frame_done_q <= last_pix;
      if (win_gate) begin
        win_data_q <= win_shift;
        win_row_q  <= row_q - ONE;
        win_col_q  <= col_q - ONE;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed/randomized bench for window_3x3_gen on an 8x6 frame, checked against
// a frame-array model that slices each expected neighbourhood out of the image.
module tb_window_3x3_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_pixel = '0;
  logic            win_valid;
  logic [9*DW-1:0] win_data;
  logic [CW-1:0]   win_row, win_col;
  logic            frame_done;

  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pixel(in_pixel),
    .win_valid(win_valid), .win_data(win_data), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]   img [H][W];
  int              mr = 0, mc = 0;
  logic [9*DW-1:0] hold_data = '0;
  logic [CW-1:0]   hold_row = '0, hold_col = '0;
  int              win_cnt = 0, fd_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0;
    hold_data = '0; hold_row = '0; hold_col = '0;
  endtask

  // One clock: apply inputs, predict from the image array, compare after the edge.
  task automatic step(input logic v, input logic [DW-1:0] p);
    logic ev, efd;
    ev = 1'b0; efd = 1'b0;
    in_valid = v; in_pixel = p;
    if (v) begin
      img[mr][mc] = p;
      ev  = (mr >= 2) && (mc >= 2);
      efd = (mr == H-1) && (mc == W-1);
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            hold_data[DW*(3*i+j) +: DW] = img[mr-2+i][mc-2+j];
        hold_row = CW'(mr - 1);
        hold_col = CW'(mc - 1);
      end
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
    @(posedge clk); #1;
    check("win_valid", 128'(win_valid), 128'(ev));
    check("frame_done", 128'(frame_done), 128'(efd));
    check("win_data", 128'(win_data), 128'(hold_data));
    check("win_row", 128'(win_row), 128'(hold_row));
    check("win_col", 128'(win_col), 128'(hold_col));
    if (win_valid) win_cnt++;
    if (frame_done) begin
      fd_cnt++;
      check("fd_centre_row", 128'(win_row), 128'(H-2));
      check("fd_centre_col", 128'(win_col), 128'(W-2));
    end
    in_valid = 1'b0;
  endtask

  // mode 0: pixel=row*16+col; mode 1: random pixels. Stops after (stop_r,stop_c) if >=0.
  task automatic drive_frame(input int mode, input int idle_pct, input int stop_r, input int stop_c);
    logic [DW-1:0] pix;
    logic [9*DW-1:0] first_exp;
    first_exp = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (idle_pct > 0 && $urandom_range(99) < idle_pct)
          step(1'b0, DW'($urandom));
        pix = (mode == 0) ? DW'(r*16 + c) : DW'($urandom);
        step(1'b1, pix);
        if (mode == 0 && r == 2 && c == 2) begin
          check("first_win_data", 128'(win_data), 128'(first_exp));
          check("first_win_row", 128'(win_row), 128'(1));
          check("first_win_col", 128'(win_col), 128'(1));
        end
        if (mode == 0 && r == 3 && c == 2) begin
          check("wrap_col", 128'(win_col), 128'(1));
          check("wrap_left_pix", 128'(win_data[DW*6 +: DW]), 128'(8'h30));
        end
        if (r == stop_r && c == stop_c) return;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(win_valid), 128'(0));
    check("rst_fd", 128'(frame_done), 128'(0));
    check("rst_data", 128'(win_data), 128'(0));
    check("rst_rowcol", 128'({win_row, win_col}), 128'(0));
    @(negedge clk); reset = 1'b1;
    model_reset();

    // Continuous pattern frame
    win_cnt = 0; fd_cnt = 0;
    drive_frame(0, 0, -1, -1);
    check("frame1_windows", 128'(win_cnt), 128'((W-2)*(H-2)));
    check("frame1_fd", 128'(fd_cnt), 128'(1));

    // Same pattern with ~50% idle cycles
    win_cnt = 0; fd_cnt = 0;
    drive_frame(0, 50, -1, -1);
    check("gappy_windows", 128'(win_cnt), 128'((W-2)*(H-2)));
    check("gappy_fd", 128'(fd_cnt), 128'(1));

    // Two back-to-back random frames
    win_cnt = 0; fd_cnt = 0;
    drive_frame(1, 0, -1, -1);
    drive_frame(1, 20, -1, -1);
    check("b2b_windows", 128'(win_cnt), 128'(2*(W-2)*(H-2)));
    check("b2b_fd", 128'(fd_cnt), 128'(2));

    // Asynchronous reset mid-frame after pixel (3,4)
    drive_frame(0, 0, 3, 4);
    check("pre_rst_valid", 128'(win_valid), 128'(1));
    #3 reset = 1'b0;
    #1;
    check("async_rst_valid", 128'(win_valid), 128'(0));
    check("async_rst_fd", 128'(frame_done), 128'(0));
    check("async_rst_data", 128'(win_data), 128'(0));
    #2 reset = 1'b1;
    model_reset();
    win_cnt = 0; fd_cnt = 0;
    drive_frame(1, 30, -1, -1);
    check("post_rst_windows", 128'(win_cnt), 128'((W-2)*(H-2)));
    check("post_rst_fd", 128'(fd_cnt), 128'(1));

    // Idle tail: nothing emitted without input
    win_cnt = 0;
    repeat (5) step(1'b0, 8'hAA);
    check("idle_windows", 128'(win_cnt), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
